// File: rtl/line_profile_seq.sv
// line_profile_seq: step-table driven line stimulus sequencer.
// Jumps or ramps line_theta per step, holds, then checks robot heading.
module line_profile_seq #(
    parameter int THETA_W = 13,
    parameter int DEPTH   = 16,
    parameter int HOLD_W  = 24,
    parameter int RATE_W  = 4,
    parameter int TOL     = 10,
    parameter int ERR_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic signed [THETA_W-1:0] wr_theta,
    input  logic                      wr_present,
    input  logic                      wr_ramp,
    input  logic [RATE_W-1:0]         wr_rate,
    input  logic [HOLD_W-1:0]         wr_hold,
    input  logic                      wr_check,
    input  logic [$clog2(DEPTH):0]    num_steps,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [THETA_W-1:0] theta_robot,
    output logic signed [THETA_W-1:0] line_theta,
    output logic                      line_present,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH)-1:0]  step_idx,
    output logic                      chk_fail,
    output logic [ERR_W-1:0]          err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [THETA_W-1:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RAMP,
        HOLD,
        CHECK
    } state_t;

    typedef struct packed {
        logic [THETA_W-1:0] theta;
        logic               present;
        logic               ramp;
        logic [RATE_W-1:0]  rate;
        logic [HOLD_W-1:0]  hold;
        logic               check;
    } entry_t;

    entry_t tbl [DEPTH];
    entry_t ent;

    state_t state, state_nxt;

    logic signed [THETA_W-1:0] theta_nxt;
    logic                      present_nxt;
    logic                      busy_nxt;
    logic                      done_nxt;
    logic [AW-1:0]             idx_nxt;
    logic                      fail_nxt;
    logic [ERR_W-1:0]          err_nxt;
    logic [RATE_W-1:0]         div_cnt, div_nxt;
    logic [HOLD_W-1:0]         hold_cnt, hold_nxt;
    logic [AW:0]               n_run, n_run_nxt;

    logic signed [THETA_W-1:0] tgt;
    logic signed [THETA_W:0]   to_tgt;
    logic signed [THETA_W:0]   head_err;
    logic [THETA_W:0]          head_abs;
    logic signed [THETA_W-1:0] theta_step;
    logic                      head_bad;
    logic                      last_step;
    logic                      adv;

    assign ent = tbl[step_idx];
    assign tgt = $signed(ent.theta);

    // Table writes are accepted only while no sequence is running.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            tbl[wr_addr] <= '{
                theta:   wr_theta,
                present: wr_present,
                ramp:    wr_ramp,
                rate:    wr_rate,
                hold:    wr_hold,
                check:   wr_check
            };
        end
    end

    // Ramp direction, next ramp value and heading-window test.
    always_comb begin
        to_tgt   = $signed({tgt[THETA_W-1], tgt})
                 - $signed({line_theta[THETA_W-1], line_theta});
        head_err = $signed({theta_robot[THETA_W-1], theta_robot})
                 - $signed({line_theta[THETA_W-1], line_theta});
        head_abs = head_err[THETA_W] ? $unsigned(-head_err)
                                     : $unsigned(head_err);
        head_bad = head_abs > (THETA_W+1)'(TOL);
        theta_step = to_tgt[THETA_W] ? line_theta - ONE
                                     : line_theta + ONE;
        last_step = ({1'b0, step_idx} + 1'b1) == n_run;
    end

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        state_nxt   = state;
        theta_nxt   = line_theta;
        present_nxt = line_present;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        idx_nxt     = step_idx;
        fail_nxt    = 1'b0;
        err_nxt     = err_cnt;
        div_nxt     = div_cnt;
        hold_nxt    = hold_cnt;
        n_run_nxt   = n_run;
        adv         = 1'b0;
        if (abort && state != IDLE) begin
            state_nxt   = IDLE;
            busy_nxt    = 1'b0;
            present_nxt = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        err_nxt   = '0;
                        idx_nxt   = '0;
                        n_run_nxt = num_steps;
                        if (num_steps == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = LOAD;
                            busy_nxt  = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    present_nxt = ent.present;
                    div_nxt     = '0;
                    hold_nxt    = HOLD_W'(1);
                    if (!ent.ramp) begin
                        theta_nxt = tgt;
                        state_nxt = HOLD;
                    end else if (line_theta == tgt) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RAMP;
                    end
                end
                RAMP: begin
                    if (div_cnt == ent.rate) begin
                        div_nxt   = '0;
                        theta_nxt = theta_step;
                        if (theta_step == tgt) state_nxt = HOLD;
                    end else begin
                        div_nxt = div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt >= ent.hold) begin
                        if (ent.check) state_nxt = CHECK;
                        else           adv       = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (head_bad) begin
                        fail_nxt = 1'b1;
                        if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
                    end
                    adv = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
            if (adv) begin
                if (last_step) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = step_idx + 1'b1;
                    state_nxt = LOAD;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            line_theta   <= '0;
            line_present <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            step_idx     <= '0;
            chk_fail     <= 1'b0;
            err_cnt      <= '0;
            div_cnt      <= '0;
            hold_cnt     <= '0;
            n_run        <= '0;
        end else begin
            state        <= state_nxt;
            line_theta   <= theta_nxt;
            line_present <= present_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            step_idx     <= idx_nxt;
            chk_fail     <= fail_nxt;
            err_cnt      <= err_nxt;
            div_cnt      <= div_nxt;
            hold_cnt     <= hold_nxt;
            n_run        <= n_run_nxt;
        end
    end

endmodule

// File: tb/tb_line_profile_seq.sv
// tb_line_profile_seq: timeline reference model for line_profile_seq.
// Each step is expanded into per-cycle expected outputs and compared.
module tb_line_profile_seq;

    localparam int TW    = 13;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HW    = 24;
    localparam int RW    = 4;
    localparam int TOL   = 10;
    // narrow error counter so one 16-step sequence can reach saturation
    localparam int EW    = 4;
    localparam int EMAX  = (1 << EW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic signed [TW-1:0] wr_theta = '0;
    logic                 wr_present = 1'b0;
    logic                 wr_ramp = 1'b0;
    logic [RW-1:0]        wr_rate = '0;
    logic [HW-1:0]        wr_hold = '0;
    logic                 wr_check = 1'b0;
    logic [AW:0]          num_steps = '0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic signed [TW-1:0] theta_robot = '0;
    logic signed [TW-1:0] line_theta;
    logic                 line_present;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        step_idx;
    logic                 chk_fail;
    logic [EW-1:0]        err_cnt;

    line_profile_seq #(
        .THETA_W(TW), .DEPTH(DEPTH), .HOLD_W(HW),
        .RATE_W(RW), .TOL(TOL), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_theta(wr_theta),
        .wr_present(wr_present), .wr_ramp(wr_ramp),
        .wr_rate(wr_rate), .wr_hold(wr_hold), .wr_check(wr_check),
        .num_steps(num_steps), .start(start), .abort(abort),
        .theta_robot(theta_robot),
        .line_theta(line_theta), .line_present(line_present),
        .busy(busy), .done(done), .step_idx(step_idx),
        .chk_fail(chk_fail), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int theta; bit pres; bit ramp;
        int rate;  int hold; bit check; int off;
    } ent_t;

    typedef struct {
        int theta; bit pres; bit busy; bit done;
        int idx;   bit cf;   int err;  int rob;
    } snap_t;

    ent_t  tm [DEPTH];
    snap_t tl [$];
    int    m_theta = 0;
    bit    m_pres  = 1'b1;
    int    m_err   = 0;
    int    m_idx   = 0;
    int    total   = 0;
    int    bad     = 0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp(input snap_t s);
        chk("line_theta", line_theta, s.theta);
        chk("line_present", line_present, s.pres);
        chk("busy", busy, s.busy);
        chk("done", done, s.done);
        chk("step_idx", step_idx, s.idx);
        chk("chk_fail", chk_fail, s.cf);
        chk("err_cnt", err_cnt, s.err);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_rob();
        return int'($urandom_range(0, 8190)) - 4095;
    endfunction

    function automatic snap_t idle_snap();
        snap_t s;
        s.theta = m_theta; s.pres = m_pres; s.busy = 1'b0;
        s.done = 1'b0; s.idx = m_idx; s.cf = 1'b0;
        s.err = m_err; s.rob = 0;
        return s;
    endfunction

    function automatic ent_t mk(input int th, input bit pr, input bit rp,
                                input int rt, input int hd, input bit ck,
                                input int off);
        ent_t e;
        e.theta = th; e.pres = pr; e.ramp = rp; e.rate = rt;
        e.hold = hd; e.check = ck; e.off = off;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        int offs [10];
        offs = '{0, 3, -7, 10, -10, 11, -11, 14, -300, 300};
        return mk(int'($urandom_range(0, 40)) - 20,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), offs[$urandom_range(0, 9)]);
    endfunction

    task automatic wr_ent(input int a, input ent_t e);
        wr_addr = AW'(a); wr_theta = TW'(e.theta);
        wr_present = e.pres; wr_ramp = e.ramp;
        wr_rate = RW'(e.rate); wr_hold = HW'(e.hold);
        wr_check = e.check; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tm[a] = e;
        cmp(idle_snap());
    endtask

    // expected outputs after each clock edge from the start edge onward
    task automatic build(input int n);
        snap_t s;
        ent_t  e;
        int d, dir, len, h;
        tl.delete();
        s = idle_snap();
        s.err = 0; s.idx = 0; s.rob = rnd_rob();
        if (n == 0) begin
            s.done = 1'b1; tl.push_back(s);
            s.done = 1'b0; tl.push_back(s);
            return;
        end
        s.busy = 1'b1; tl.push_back(s);
        for (int i = 0; i < n; i++) begin
            e = tm[i];
            s.pres = e.pres;
            if (!e.ramp) s.theta = e.theta;
            s.rob = rnd_rob(); tl.push_back(s);
            if (e.ramp) begin
                d   = e.theta - s.theta;
                dir = (d < 0) ? -1 : 1;
                len = ((d < 0) ? -d : d) * (e.rate + 1);
                for (int j = 1; j <= len; j++) begin
                    if (j % (e.rate + 1) == 0) s.theta += dir;
                    s.rob = rnd_rob(); tl.push_back(s);
                end
            end
            h = (e.hold < 1) ? 1 : e.hold;
            for (int j = 1; j < h; j++) begin
                s.rob = rnd_rob(); tl.push_back(s);
            end
            if (e.check) begin
                s.rob = e.theta + e.off; tl.push_back(s);
                if (e.off > TOL || e.off < -TOL) begin
                    s.cf = 1'b1;
                    if (s.err < EMAX) s.err++;
                end
            end
            if (i == n - 1) begin
                s.busy = 1'b0; s.done = 1'b1;
            end else begin
                s.idx = i + 1;
            end
            s.rob = rnd_rob(); tl.push_back(s);
            s.cf = 1'b0;
        end
        s.done = 1'b0; s.rob = rnd_rob(); tl.push_back(s);
    endtask

    task automatic run(input int n, input int ak);
        snap_t last;
        last = idle_snap();
        num_steps = (AW+1)'(n); start = 1'b1; abort = 1'b0;
        for (int k = 0; k < tl.size(); k++) begin
            tick();
            start = 1'b0; wr_en = 1'b0;
            cmp(tl[k]);
            last = tl[k];
            if (k == ak) begin
                abort = 1'b1; start = 1'b1;
                tick();
                abort = 1'b0; start = 1'b0; wr_en = 1'b0;
                last.busy = 1'b0; last.pres = 1'b1;
                last.done = 1'b0; last.cf = 1'b0;
                cmp(last);
                break;
            end
            theta_robot = TW'(tl[k].rob);
            if (tl[k].busy) begin
                start = 1'($urandom_range(0, 1));
                num_steps = (AW+1)'($urandom_range(0, 16));
                wr_en = 1'b1; wr_addr = AW'(k);
                wr_theta = TW'($urandom); wr_present = 1'($urandom);
                wr_ramp = 1'($urandom); wr_rate = RW'($urandom);
                wr_hold = HW'($urandom_range(0, 9));
                wr_check = 1'($urandom);
            end
        end
        start = 1'b0; wr_en = 1'b0;
        m_theta = last.theta; m_pres = last.pres;
        m_err = last.err; m_idx = last.idx;
    endtask

    initial begin
        int ak;
        int n;
        repeat (3) @(posedge clk);
        #1;
        cmp(idle_snap());
        rst_n = 1'b1;
        tick();
        cmp(idle_snap());

        wr_ent(0, mk(150, 1, 0, 0, 20, 1, 3));
        build(1); run(1, -1);
        chk("jump_theta", line_theta, 150);

        wr_ent(0, mk(0, 1, 0, 0, 0, 0, 0));
        wr_ent(1, mk(1050, 0, 1, 9, 0, 0, 0));
        wr_ent(2, mk(-1650, 1, 1, 0, 2, 1, 11));
        wr_ent(3, mk(-1650, 1, 0, 0, 0, 1, 10));
        wr_ent(4, mk(-1650, 1, 0, 0, 0, 1, -11));
        build(5); run(5, -1);
        chk("tol_err", err_cnt, 2);

        num_steps = 3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        cmp(idle_snap());
        tick();
        cmp(idle_snap());

        wr_ent(0, mk(600, 0, 1, 1, 0, 0, 0));
        build(1);
        ak = -1;
        for (int k = 0; k < tl.size(); k++)
            if (ak < 0 && tl[k].busy && tl[k].theta == 300) ak = k;
        run(1, ak);
        repeat (4) begin
            tick();
            cmp(idle_snap());
        end
        chk("abort_theta", line_theta, 300);
        build(0); run(0, -1);

        wr_ent(0, mk(20, 1, 0, 0, 3, 0, 0));
        wr_ent(1, mk(-20, 0, 0, 0, 2, 1, 0));
        build(2); run(2, -1);

        for (int i = 0; i < DEPTH; i++) wr_ent(i, mk(7, 1, 0, 0, 0, 1, 200));
        build(16); run(16, -1);
        chk("err_sat", err_cnt, EMAX);

        num_steps = 16; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        m_theta = 0; m_pres = 1'b1; m_err = 0; m_idx = 0;
        cmp(idle_snap());
        tick();
        rst_n = 1'b1;
        tick();
        cmp(idle_snap());

        repeat (24) begin
            for (int i = 0; i < DEPTH; i++) wr_ent(i, rnd_ent());
            n = int'($urandom_range(0, 16));
            build(n);
            ak = -1;
            if (n > 0 && $urandom_range(0, 3) == 0)
                ak = int'($urandom_range(0, tl.size() - 3));
            run(n, ak);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
